systolic_skew_feeder: RTL
=========================

// Module: systolic_skew_feeder
// PURPOSE
//  Upstream stage of systolic_array_4x4: accepts one A tile (N x K) and one B tile (K x N) via valid/ready,
//  pulses the array clear, then streams both tiles diagonally skewed (row i / column j delayed i / j beats)
//  onto the array's left and top edges with per-lane valid bits. Holds off the next tile until array done.
// PARAMETERS
//  N   4  array dimension (rows of A, columns of B, lanes per edge)
//  DW  8  signed element width
//  K   4  reduction depth (columns of A = rows of B), K >= 1
// PORTS
//  clk           in   1        single clock, rising edge
//  rst_n         in   1        asynchronous, active-low reset
//  in_valid      in   1        tile pair offered
//  in_ready      out  1        feeder can accept a tile pair
//  a_tile_flat   in   N*K*DW   A[i][k] at [(i*K+k)*DW +: DW]
//  b_tile_flat   in   K*N*DW   B[k][j] at [(k*N+j)*DW +: DW]
//  abort         in   1        sync: drop current tile, return to IDLE
//  arr_done      in   1        done pulse from systolic array
//  clr           out  1        one-cycle accumulator clear to array
//  a_left_flat   out  N*DW     row-lane data, lane i at [i*DW +: DW]
//  a_v_row_flat  out  N        row-lane valids
//  b_top_flat    out  N*DW     column-lane data, lane j at [j*DW +: DW]
//  b_v_col_flat  out  N        column-lane valids
//  busy          out  1        high from accept until return to IDLE
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE, tile regs 0; in_ready=1, clr=0, busy=0, all data/valid outputs 0.
//  All outputs registered except in_ready (= state==IDLE && !abort).
//  FSM: IDLE -(in_valid&&in_ready)-> CLR -> STREAM -(t==K+N-2)-> WAIT_DONE -(arr_done)-> IDLE.
//  Accept edge E0: capture both tiles. Cycle after E0: clr=1, busy=1, lanes all 0/invalid.
//  STREAM: beat counter t=0..K+N-2; beat t on outputs in cycle t+2 after E0 (K+N-1 = 7 beats for 4x4).
//   Row lane i: valid iff 0 <= t-i < K; data = A[i][t-i] when valid, else 0.
//   Col lane j: valid iff 0 <= t-j < K; data = B[t-j][j] when valid, else 0.
//   Invalid lanes always drive data 0 (no stale values).
//  WAIT_DONE: lanes 0/invalid, busy=1; arr_done sampled high -> IDLE, in_ready=1 the following cycle.
//  arr_done outside WAIT_DONE is ignored (no state effect).
//  abort=1 in any state: next cycle IDLE, clr/valids/data 0, busy=0; abort wins over a same-cycle in_valid
//   (no accept). Tile regs retain content but are never re-emitted.
//  in_valid while not IDLE: not accepted, no side effect; in_valid may drop without accept.
//  Counter width clog2(K+N); no wrap: STREAM exits on terminal count exactly once per tile.
//  Reset asserted mid-STREAM: outputs drop to 0 asynchronously; array gets no clr, so next tile's CLR
//   state is the only clear path.
// STRUCTURE
//  systolic_pkg: N/DW/K defaults, state encoding localparams (IDLE, CLR, STREAM, WAIT_DONE),
//   tile index helper functions shared with systolic_array_4x4 flattening.
//  Sub-module skew_lane (one per lane, 2N instances): given t, lane index and its K captured elements,
//   registers valid and selected element (0 when invalid). Top holds FSM, counter, tile capture.
// TESTING
//  1 Reset: rst_n=0 -> in_ready=1, busy=0, clr=0, all valids/data 0; release, hold 10 cycles -> unchanged.
//  2 Skew: A[i][k]=4i+k+1, B[k][j]=16+4k+j -> clr at E0+1; beat t=3: a_v_row=4'b1111, lane2=A[2][1]=10,
//    b_v_col=4'b1111, lane3=B[0][3]=19; beat 6: a_v_row=4'b1000, lane3=A[3][3]=16, others 0.
//  3 End-to-end with systolic_array_4x4, A=B=identity -> C diagonal 1, off-diagonal 0, arr_done pulse,
//    in_ready rises the cycle after arr_done is sampled.
//  4 Backpressure: in_valid held high through tile 1 -> exactly one accept per IDLE; second tile
//    captured on the in_ready cycle, first beat clr-preceded again.
//  5 Abort at beat t=2 together with in_valid=1 -> next cycle all valids 0, busy=0, no accept; later tile
//    runs normally.
//  6 Spurious arr_done during STREAM -> ignored, all 7 beats emitted; async rst_n at beat 4 -> outputs 0
//    immediately.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic datapath: default array geometry,
// the feeder FSM state encoding, and tile flattening helpers that give the
// bit offset of a matrix element inside a flat tile vector. The array uses
// the same helpers, so both sides agree on the layout.
package systolic_pkg;

  localparam int SA_N  = 4;  // array dimension
  localparam int SA_DW = 8;  // signed element width
  localparam int SA_K  = 4;  // reduction depth

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLR       = 2'd1,
    ST_STREAM    = 2'd2,
    ST_WAIT_DONE = 2'd3
  } feeder_state_e;

  // A is N x K, row-major: A[i][k] at [(i*K+k)*DW +: DW]
  function automatic int a_off(input int i, input int k, input int kk, input int dw);
    return (i * kk + k) * dw;
  endfunction

  // B is K x N, row-major: B[k][j] at [(k*N+j)*DW +: DW]
  function automatic int b_off(input int k, input int j, input int nn, input int dw);
    return (k * nn + j) * dw;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_lane.sv
// One edge lane of the skew feeder. Given the beat number that will be on
// the outputs next cycle, the lane's index (its skew) and the K elements it
// streams, it registers the lane valid and the selected element.
//   clk, rst_n : clock, asynchronous active-low reset
//   emit       : next cycle is a streaming beat
//   beat       : beat index t shown next cycle
//   elems      : the lane's K elements, element k at [k*DW +: DW]
//   valid      : registered lane valid (0 <= t-LANE < K)
//   data       : registered element t-LANE, 0 whenever invalid
module skew_lane #(
  parameter int K    = 4,
  parameter int DW   = 8,
  parameter int CW   = 3,
  parameter int LANE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          emit,
  input  logic [CW-1:0] beat,
  input  logic [K*DW-1:0] elems,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic          valid_nxt;
  logic [DW-1:0] data_nxt;

  always_comb begin
    int rel;
    // NOTE: every output of a combinational block gets a default up front so
    // no path leaves it unassigned, which would otherwise infer a latch.
    valid_nxt = 1'b0;
    data_nxt  = '0;
    rel       = int'(beat) - LANE;
    // Explicit compare loop keeps the element select in range even for
    // beats outside the lane's window, where data must stay 0.
    for (int k = 0; k < K; k++) begin
      if (emit && rel == k) begin
        valid_nxt = 1'b1;
        data_nxt  = elems[k*DW +: DW];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= valid_nxt;
      data  <= data_nxt;
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Upstream stage of the systolic array. Accepts an A (N x K) / B (K x N)
// tile pair, pulses clr for one cycle, then streams the tiles diagonally
// skewed onto the array's left (rows of A) and top (columns of B) edges,
// and waits for the array's done pulse before accepting the next pair.
//   clk, rst_n     : clock, asynchronous active-low reset
//   in_valid/ready : tile pair handshake (in_ready combinational)
//   a_tile_flat    : A[i][k] at [(i*K+k)*DW +: DW]
//   b_tile_flat    : B[k][j] at [(k*N+j)*DW +: DW]
//   abort          : drop the current tile and return to idle
//   arr_done       : done pulse from the array, honoured only while waiting
//   clr            : one-cycle accumulator clear
//   a_left_flat    : row lanes, lane i at [i*DW +: DW]; a_v_row_flat valids
//   b_top_flat     : column lanes, lane j at [j*DW +: DW]; b_v_col_flat valids
//   busy           : high from accept until return to idle
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N  = SA_N,
  parameter int DW = SA_DW,
  parameter int K  = SA_K
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*K*DW-1:0] a_tile_flat,
  input  logic [K*N*DW-1:0] b_tile_flat,
  input  logic            abort,
  input  logic            arr_done,
  output logic            clr,
  output logic [N*DW-1:0] a_left_flat,
  output logic [N-1:0]    a_v_row_flat,
  output logic [N*DW-1:0] b_top_flat,
  output logic [N-1:0]    b_v_col_flat,
  output logic            busy
);

  localparam int CW   = $clog2(K + N);
  localparam int LAST = K + N - 2;  // terminal beat index

  feeder_state_e       state, state_nxt;
  logic [CW-1:0]       t, t_nxt;
  logic [N*K*DW-1:0]   a_reg;
  logic [K*N*DW-1:0]   b_reg;
  logic                accept;
  logic                emit;

  assign in_ready = (state == ST_IDLE) && !abort;
  assign accept   = in_valid && in_ready;

  // t_nxt is the beat shown next cycle; it is 0 outside streaming so the
  // counter restarts cleanly for every tile and never wraps.
  always_comb begin
    state_nxt = state;
    t_nxt     = '0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:      if (in_valid) state_nxt = ST_CLR;
        ST_CLR:       state_nxt = ST_STREAM;
        ST_STREAM: begin
          if (t == CW'(LAST)) state_nxt = ST_WAIT_DONE;
          else                t_nxt     = t + 1'b1;
        end
        ST_WAIT_DONE: if (arr_done) state_nxt = ST_IDLE;
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from next-state values so they line up with the
  // state they describe: clr in the CLR cycle, beat t in the STREAM cycle t.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      t     <= '0;
      clr   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
      clr   <= (state_nxt == ST_CLR);
      busy  <= (state_nxt != ST_IDLE);
    end
  end

  // NOTE: the tile holding registers are reset too, so a tile that was never
  // loaded reads as zeros rather than X after power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (accept) begin
      a_reg <= a_tile_flat;
      b_reg <= b_tile_flat;
    end
  end

  assign emit = (state_nxt == ST_STREAM);

  for (genvar i = 0; i < N; i++) begin : g_row
    skew_lane #(.K(K), .DW(DW), .CW(CW), .LANE(i)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .emit  (emit),
      .beat  (t_nxt),
      .elems (a_reg[a_off(i, 0, K, DW) +: K*DW]),
      .valid (a_v_row_flat[i]),
      .data  (a_left_flat[i*DW +: DW])
    );
  end

  for (genvar j = 0; j < N; j++) begin : g_col
    logic [K*DW-1:0] col_elems;
    // Column j of B is strided in the flat tile; gather it into lane order.
    for (genvar k = 0; k < K; k++) begin : g_gather
      assign col_elems[k*DW +: DW] = b_reg[b_off(k, j, N, DW) +: DW];
    end
    skew_lane #(.K(K), .DW(DW), .CW(CW), .LANE(j)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .emit  (emit),
      .beat  (t_nxt),
      .elems (col_elems),
      .valid (b_v_col_flat[j]),
      .data  (b_top_flat[j*DW +: DW])
    );
  end

endmodule
